trig_bank_arb: RTL and testbench

Round-robin arbiter and load sequencer that shares one W-bit D-flip-flop register (a bank of `trig` cells) between N requesters. A requester raises `req`, receives a one-cycle `gnt`, and its data word is captured into the shared register; the register is then locked for HOLD cycles before the next arbitration. Sits between requesting datapath blocks and the shared storage register, and exposes the register contents and the identity of the last writer.

---
 rtl/trig_bank_arb.sv | 102 ++++++++++
 tb/tb_trig_bank_arb.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/trig_bank_arb.sv
// Round-robin arbiter and load sequencer that shares one W-bit register between N requesters.
// After each successful load, the register stays locked for HOLD cycles.
module trig_bank_arb #(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int HOLD = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*W-1:0]     din,
  output logic [N-1:0]       gnt,
  output logic [W-1:0]       q,
  output logic [$clog2(N)-1:0] q_src,
  output logic               q_vld,
  output logic               busy
);

  localparam int S  = $clog2(N);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]    r_state;
  logic [S-1:0]  r_ptr;
  logic [S-1:0]  r_win;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_q;
  logic [S-1:0]  r_q_src;
  logic          r_q_vld;

  logic [S-1:0]  w_win;
  logic [W-1:0]  w_sel;
  logic          w_win_req;
  logic [N-1:0]  w_onehot;

  // Scan from the farthest offset down to the nearest, so the first set bit at or after r_ptr wins.
  always_comb begin : p_rr
    logic [S-1:0] w_idx;
    w_win = '0;
    w_idx = '0;
    for (int unsigned k = N; k > 0; k--) begin
      w_idx = r_ptr + S'(k - 1);
      if (req[w_idx]) w_win = w_idx;
    end
  end

  assign w_sel     = din[int'(r_win)*W +: W];
  assign w_win_req = req[r_win];
  assign w_onehot  = {{(N-1){1'b0}}, 1'b1} << r_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_q_src <= '0;
      r_q_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_win   <= w_win;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_win_req) begin
            r_q     <= w_sel;
            r_q_src <= r_win;
            r_q_vld <= 1'b1;
            r_ptr   <= r_win + S'(1);
            if (HOLD > 0) begin
              r_cnt   <= CW'((HOLD > 0) ? HOLD - 1 : 0);
              r_state <= ST_HOLD;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (r_cnt == '0) r_state <= ST_IDLE;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt   = (r_state == ST_LOAD && w_win_req) ? w_onehot : '0;
  assign q     = r_q;
  assign q_src = r_q_src;
  assign q_vld = r_q_vld;
  assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_trig_bank_arb.sv
// Bench for trig_bank_arb: HOLD=3 and HOLD=0 instances share stimulus and are
// checked each cycle against a transaction-level reference model.
module tb_trig_bank_arb;

  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   din;

  logic [N-1:0] gnt_a, gnt_b;
  logic [W-1:0] q_a, q_b;
  logic [S-1:0] src_a, src_b;
  logic         vld_a, vld_b, busy_a, busy_b;

  trig_bank_arb #(.W(W), .N(N), .HOLD(3)) u_a (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt_a), .q(q_a), .q_src(src_a), .q_vld(vld_a), .busy(busy_a)
  );

  trig_bank_arb #(.W(W), .N(N), .HOLD(0)) u_b (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt_b), .q(q_b), .q_src(src_b), .q_vld(vld_b), .busy(busy_b)
  );

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  // Model: per instance, a pending load for a chosen winner, plus a count of remaining lock cycles.
  int         hold_cfg [2] = '{3, 0};
  bit         m_pend   [2];
  int         m_win    [2];
  int         m_hold   [2];
  int         m_ptr    [2];
  logic [7:0] m_q      [2];
  int         m_src    [2];
  bit         m_vld    [2];

  function automatic logic [N*W-1:0] mk(input logic [7:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [N-1:0] exp_gnt(input int d);
    logic [N-1:0] g;
    g = '0;
    if (m_pend[d] && req[m_win[d]]) g[m_win[d]] = 1'b1;
    return g;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_edge(input int d);
    if (rst) begin
      m_pend[d] = 0; m_hold[d] = 0; m_ptr[d] = 0;
      m_q[d] = '0; m_src[d] = 0; m_vld[d] = 0;
    end else if (m_pend[d]) begin
      m_pend[d] = 0;
      if (req[m_win[d]]) begin
        m_q[d]    = din[m_win[d]*W +: W];
        m_src[d]  = m_win[d];
        m_vld[d]  = 1;
        m_ptr[d]  = (m_win[d] + 1) % N;
        m_hold[d] = hold_cfg[d];
      end
    end else if (m_hold[d] > 0) begin
      m_hold[d]--;
    end else if (req != '0) begin
      for (int k = N - 1; k >= 0; k--)
        if (req[(m_ptr[d] + k) % N]) m_win[d] = (m_ptr[d] + k) % N;
      m_pend[d] = 1;
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] d, input bit check);
    rst = r; req = rq; din = d;
    #1;
    if (check) begin
      chk("a_gnt",  32'(gnt_a),  32'(exp_gnt(0)));
      chk("a_q",    32'(q_a),    32'(m_q[0]));
      chk("a_src",  32'(src_a),  32'(m_src[0]));
      chk("a_vld",  32'(vld_a),  32'(m_vld[0]));
      chk("a_busy", 32'(busy_a), 32'(m_pend[0] || m_hold[0] > 0));
      chk("b_gnt",  32'(gnt_b),  32'(exp_gnt(1)));
      chk("b_q",    32'(q_b),    32'(m_q[1]));
      chk("b_src",  32'(src_b),  32'(m_src[1]));
      chk("b_vld",  32'(vld_b),  32'(m_vld[1]));
      chk("b_busy", 32'(busy_b), 32'(m_pend[1] || m_hold[1] > 0));
    end
    model_edge(0);
    model_edge(1);
    @(negedge clk);
  endtask

  logic [N*W-1:0] d_inc;

  initial begin
    rst = 1'b1; req = '0; din = '0;
    d_inc = mk(8'h10, 8'h11, 8'h12, 8'h13);
    @(negedge clk);
    step(1'b1, '0, '0, 1'b0);
    step(1'b1, '0, '0, 1'b1);
    // Idle after reset
    for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b1);
    // Single request from requester 2, dropped once the grant has been seen
    step(1'b0, 4'b0100, mk(8'h00, 8'h00, 8'hA5, 8'h00), 1'b1);
    step(1'b0, 4'b0100, mk(8'h00, 8'h00, 8'hA5, 8'h00), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1);
    // All requesting: round-robin rotation
    for (int i = 0; i < 26; i++) step(1'b0, 4'b1111, d_inc, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1);
    // Withdrawn request during LOAD: no write, pointer not advanced
    step(1'b0, 4'b0010, mk(8'h00, 8'h77, 8'h00, 8'h00), 1'b1);
    step(1'b0, 4'b0000, mk(8'h00, 8'h77, 8'h00, 8'h00), 1'b1);
    step(1'b0, 4'b0000, '0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 4'b1111, d_inc, 1'b1);
    // Reset while locked, then all requesting restarts from requester 0
    step(1'b1, 4'b1111, d_inc, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 4'b1111, d_inc, 1'b1);
    // Pair of requesters (HOLD=0 instance alternates every 2 cycles)
    for (int i = 0; i < 10; i++) step(1'b0, 4'b0011, mk(8'h3C, 8'hC3, 8'h00, 8'h00), 1'b1);
    // Random traffic including withdrawals and occasional resets
    for (int i = 0; i < 400; i++)
      step(logic'($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)), 32'($urandom), 1'b1);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
